// File: rtl/native_in_port_if.sv
// Native video stream (vsync/hsync/de/data) as seen by the capture port.
interface native_in_port_if #(parameter int DSIZE = 24);
    logic             vsync;
    logic             hsync;
    logic             de;
    logic [DSIZE-1:0] data;

    modport master (output vsync, hsync, de, data);
    modport slave  (input  vsync, hsync, de, data);
endinterface

// File: rtl/native_in_port.sv
// Capture-side native video port: turns a vsync/de stream into FIFO writes plus
// frame/line alignment pulses, and flags lines/frames that miss hactive/vactive.
module native_in_port #(
    parameter int    DSIZE = 24,
    parameter string MODE  = "ONCE"
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic [15:0]        vactive,
    input  logic [15:0]        hactive,
    native_in_port_if.slave    vin,
    input  logic               fifo_full,
    output logic               wr_en,
    output logic [DSIZE-1:0]   wdata,
    output logic               falign,
    output logic               lalign,
    output logic               ealign,
    output logic               line_err,
    output logic               frame_err,
    output logic               overflow,
    output logic               busy
);
    localparam logic LINE_MODE = (MODE == "LINE");

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t           state, state_n;
    logic [15:0]      pcnt, pcnt_n, lcnt, lcnt_n;
    logic             s_vs, s_de;
    logic             vs_rise, de_fall, cfg_ok, start;
    logic             wr_n, fa_n, la_n, ea_n, le_n, fe_n, ovf_n;
    logic [DSIZE-1:0] wdata_n;

    // hsync carries no information the write path needs
    logic unused_hsync;
    assign unused_hsync = vin.hsync;

    assign vs_rise = vin.vsync & ~s_vs;
    assign de_fall = ~vin.de & s_de;
    assign cfg_ok  = enable && (hactive != 16'd0) && (vactive != 16'd0);

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        lcnt_n  = lcnt;
        wr_n    = 1'b0;
        wdata_n = wdata;
        fa_n    = 1'b0;
        la_n    = 1'b0;
        ea_n    = 1'b0;
        le_n    = 1'b0;
        fe_n    = 1'b0;
        ovf_n   = overflow;
        start   = 1'b0;
        case (state)
            IDLE: if (vs_rise && cfg_ok) start = 1'b1;
            ACTIVE: begin
                if (de_fall) begin
                    le_n   = (pcnt != hactive);
                    la_n   = LINE_MODE;
                    pcnt_n = 16'd0;
                    lcnt_n = lcnt + 16'd1;
                    if (lcnt + 16'd1 == vactive) begin
                        ea_n    = 1'b1;
                        state_n = DONE;
                    end
                end
                // line end is resolved first; a vsync only aborts an unfinished frame
                if (vs_rise) begin
                    if (state_n == ACTIVE) begin
                        fe_n  = 1'b1;
                        start = 1'b1;
                    end else if (cfg_ok) begin
                        start = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DONE: if (vs_rise) begin
                if (cfg_ok) start = 1'b1;
                else        state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = ACTIVE;
            fa_n    = 1'b1;
            pcnt_n  = 16'd0;
            lcnt_n  = 16'd0;
            ovf_n   = 1'b0;
        end

        // a pixel coincident with vsync belongs to the new frame
        if (state_n == ACTIVE && vin.de) begin
            if (pcnt_n < hactive) begin
                wr_n    = ~fifo_full;
                wdata_n = vin.data;
                if (fifo_full) ovf_n = 1'b1;
            end
            if (pcnt_n != 16'hFFFF) pcnt_n = pcnt_n + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            pcnt      <= '0;
            lcnt      <= '0;
            s_vs      <= 1'b0;
            s_de      <= 1'b0;
            wr_en     <= 1'b0;
            wdata     <= '0;
            falign    <= 1'b0;
            lalign    <= 1'b0;
            ealign    <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            lcnt      <= lcnt_n;
            s_vs      <= vin.vsync;
            s_de      <= vin.de;
            wr_en     <= wr_n;
            wdata     <= wdata_n;
            falign    <= fa_n;
            lalign    <= la_n;
            ealign    <= ea_n;
            line_err  <= le_n;
            frame_err <= fe_n;
            overflow  <= ovf_n;
            busy      <= (state_n == ACTIVE);
        end
    end
endmodule

// File: tb/tb_native_in_port.sv
// Directed bench for native_in_port: LINE and ONCE instances share one stream.
module tb_native_in_port;
    localparam int DSIZE = 24;

    logic              clock = 1'b0;
    logic              rst, enable, fifo_full;
    logic [15:0]       vactive, hactive;
    logic              wr_en, falign, lalign, ealign, line_err, frame_err, overflow, busy;
    logic [DSIZE-1:0]  wdata;
    logic              o_wr_en, o_falign, o_lalign, o_ealign, o_line_err, o_frame_err, o_overflow, o_busy;
    logic [DSIZE-1:0]  o_wdata;

    int nvec = 0, nbad = 0;
    int cnt_wr, cnt_fa, cnt_la, cnt_ea, cnt_le, cnt_fe, cnt_la_once, cnt_ea_once;
    int cur_line;
    logic [3:0] le_mask;

    native_in_port_if #(.DSIZE(DSIZE)) vif();

    always #5 clock = ~clock;

    native_in_port #(.DSIZE(DSIZE), .MODE("LINE")) dut (
        .clock(clock), .rst(rst), .enable(enable), .vactive(vactive), .hactive(hactive),
        .vin(vif), .fifo_full(fifo_full), .wr_en(wr_en), .wdata(wdata),
        .falign(falign), .lalign(lalign), .ealign(ealign), .line_err(line_err),
        .frame_err(frame_err), .overflow(overflow), .busy(busy));

    native_in_port #(.DSIZE(DSIZE), .MODE("ONCE")) dut_once (
        .clock(clock), .rst(rst), .enable(enable), .vactive(vactive), .hactive(hactive),
        .vin(vif), .fifo_full(fifo_full), .wr_en(o_wr_en), .wdata(o_wdata),
        .falign(o_falign), .lalign(o_lalign), .ealign(o_ealign), .line_err(o_line_err),
        .frame_err(o_frame_err), .overflow(o_overflow), .busy(o_busy));

    // advance one cycle, sample 1 ns after the edge and tally output pulses
    task automatic tick();
        @(posedge clock);
        #1;
        cnt_wr      += int'(wr_en);
        cnt_fa      += int'(falign);
        cnt_la      += int'(lalign);
        cnt_ea      += int'(ealign);
        cnt_le      += int'(line_err);
        cnt_fe      += int'(frame_err);
        cnt_la_once += int'(o_lalign);
        cnt_ea_once += int'(o_ealign);
        if (line_err && cur_line < 4) le_mask[cur_line] = 1'b1;
    endtask

    task automatic clr();
        cnt_wr = 0; cnt_fa = 0; cnt_la = 0; cnt_ea = 0; cnt_le = 0; cnt_fe = 0;
        cnt_la_once = 0; cnt_ea_once = 0; le_mask = 4'b0; cur_line = 0;
    endtask

    task automatic vsync_cycle();
        vif.vsync = 1'b1; tick();
        vif.vsync = 1'b0; tick();
    endtask

    task automatic send_lines(input int nl, input int l0, input int l1, input int l2, input int l3);
        int len[4];
        len = '{l0, l1, l2, l3};
        for (int i = 0; i < nl; i++) begin
            cur_line = i;
            for (int p = 0; p < len[i]; p++) begin
                vif.de = 1'b1; vif.data = 24'(32'h100000 + i * 16 + p); tick();
            end
            vif.de = 1'b0; tick(); tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        nvec++; if ({wr_en, falign, lalign, ealign, line_err, frame_err, overflow, busy} !== 8'h00) begin
            nbad++; $display("FAIL reset_outs got %b exp 00000000", {wr_en, falign, lalign, ealign, line_err, frame_err, overflow, busy}); end
        nvec++; if (wdata !== 24'h0) begin nbad++; $display("FAIL reset_wdata got %h exp 000000", wdata); end
        rst = 1'b0; tick();
        nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_nominal();
        logic [23:0] d;
        int wbad = 0;
        clr();
        vif.vsync = 1'b1; tick();
        nvec++; if (falign !== 1'b1 || busy !== 1'b1) begin nbad++; $display("FAIL nom_falign got fa=%b busy=%b exp 1 1", falign, busy); end
        vif.vsync = 1'b0;
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                d = 24'(32'hA00000 + l * 16 + p);
                vif.de = 1'b1; vif.data = d; tick();
                if (wr_en !== 1'b1 || wdata !== d) wbad++;
            end
            vif.de = 1'b0; tick();
            nvec++; if (lalign !== 1'b1 || line_err !== 1'b0) begin
                nbad++; $display("FAIL nom_line%0d got la=%b le=%b exp 1 0", l, lalign, line_err); end
            nvec++; if (ealign !== (l == 3) || o_ealign !== (l == 3) || o_lalign !== 1'b0) begin
                nbad++; $display("FAIL nom_ealign%0d got ea=%b once_ea=%b once_la=%b exp %0d %0d 0", l, ealign, o_ealign, o_lalign, l == 3, l == 3); end
            tick();
        end
        nvec++; if (wbad !== 0) begin nbad++; $display("FAIL nom_wdata got %0d bad writes exp 0", wbad); end
        nvec++; if (cnt_wr !== 32 || cnt_fa !== 1 || cnt_la !== 4 || cnt_ea !== 1) begin
            nbad++; $display("FAIL nom_counts got wr=%0d fa=%0d la=%0d ea=%0d exp 32 1 4 1", cnt_wr, cnt_fa, cnt_la, cnt_ea); end
        nvec++; if (cnt_le !== 0 || cnt_fe !== 0 || cnt_la_once !== 0 || cnt_ea_once !== 1) begin
            nbad++; $display("FAIL nom_misc got le=%0d fe=%0d once_la=%0d once_ea=%0d exp 0 0 0 1", cnt_le, cnt_fe, cnt_la_once, cnt_ea_once); end
        nvec++; if (busy !== 1'b0) begin nbad++; $display("FAIL nom_done_busy got %b exp 0", busy); end
    endtask

    task automatic test_line_len();
        clr();
        vsync_cycle();
        send_lines(4, 8, 10, 6, 8);
        nvec++; if (cnt_wr !== 30) begin nbad++; $display("FAIL len_writes got %0d exp 30", cnt_wr); end
        nvec++; if (le_mask !== 4'b0110 || cnt_le !== 2) begin
            nbad++; $display("FAIL len_line_err got mask=%b n=%0d exp 0110 2", le_mask, cnt_le); end
        nvec++; if (cnt_ea !== 1 || cnt_fe !== 0) begin nbad++; $display("FAIL len_ealign got ea=%0d fe=%0d exp 1 0", cnt_ea, cnt_fe); end
    endtask

    task automatic test_premature();
        clr();
        vsync_cycle();
        send_lines(2, 8, 8, 8, 8);
        clr();
        vif.vsync = 1'b1; tick();
        nvec++; if (frame_err !== 1'b1 || falign !== 1'b1 || ealign !== 1'b0) begin
            nbad++; $display("FAIL pre_vsync got fe=%b fa=%b ea=%b exp 1 1 0", frame_err, falign, ealign); end
        vif.vsync = 1'b0;
        send_lines(4, 8, 8, 8, 8);
        nvec++; if (cnt_wr !== 32 || cnt_ea !== 1 || cnt_fe !== 1 || cnt_le !== 0) begin
            nbad++; $display("FAIL pre_next got wr=%0d ea=%0d fe=%0d le=%0d exp 32 1 1 0", cnt_wr, cnt_ea, cnt_fe, cnt_le); end
    endtask

    task automatic test_backpressure();
        logic exp_wr;
        clr();
        vsync_cycle();
        for (int p = 0; p < 8; p++) begin
            fifo_full = (p == 3 || p == 4);
            vif.de = 1'b1; vif.data = 24'(32'hB00000 + p); tick();
            exp_wr = !(p == 3 || p == 4);
            nvec++; if (wr_en !== exp_wr || overflow !== (p >= 3)) begin
                nbad++; $display("FAIL bp_pix%0d got wr=%b ovf=%b exp %b %0d", p, wr_en, overflow, exp_wr, p >= 3); end
        end
        fifo_full = 1'b0; vif.de = 1'b0; tick(); tick();
        send_lines(3, 8, 8, 8, 8);
        nvec++; if (overflow !== 1'b1 || cnt_wr !== 30) begin
            nbad++; $display("FAIL bp_hold got ovf=%b wr=%0d exp 1 30", overflow, cnt_wr); end
        clr();
        vif.vsync = 1'b1; tick();
        nvec++; if (falign !== 1'b1 || overflow !== 1'b0) begin
            nbad++; $display("FAIL bp_clear got fa=%b ovf=%b exp 1 0", falign, overflow); end
        vif.vsync = 1'b0;
        send_lines(4, 8, 8, 8, 8);
        nvec++; if (cnt_wr !== 32 || overflow !== 1'b0) begin
            nbad++; $display("FAIL bp_next got wr=%0d ovf=%b exp 32 0", cnt_wr, overflow); end
    endtask

    task automatic test_simul();
        clr();
        vif.vsync = 1'b1; vif.de = 1'b1; vif.data = 24'hC0FFEE; tick();
        nvec++; if (falign !== 1'b1 || wr_en !== 1'b1 || wdata !== 24'hC0FFEE) begin
            nbad++; $display("FAIL sim_vs_de got fa=%b wr=%b wd=%h exp 1 1 c0ffee", falign, wr_en, wdata); end
        for (int p = 1; p < 8; p++) begin vif.data = 24'(p); tick(); end
        vif.de = 1'b0; vif.vsync = 1'b0; tick(); tick();
        cur_line = 1;
        for (int l = 1; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin vif.de = 1'b1; vif.data = 24'(l * 16 + p); tick(); end
            if (l < 3) begin vif.de = 1'b0; tick(); tick(); end
        end
        nvec++; if (cnt_wr !== 32 || cnt_le !== 0) begin nbad++; $display("FAIL sim_writes got wr=%0d le=%0d exp 32 0", cnt_wr, cnt_le); end
        // last line ends in the very cycle a new vsync rises
        vif.de = 1'b0; vif.vsync = 1'b1; tick();
        nvec++; if (lalign !== 1'b1 || ealign !== 1'b1 || falign !== 1'b1 || frame_err !== 1'b0 || busy !== 1'b1) begin
            nbad++; $display("FAIL sim_end_vs got la=%b ea=%b fa=%b fe=%b busy=%b exp 1 1 1 0 1", lalign, ealign, falign, frame_err, busy); end
        vif.vsync = 1'b0; tick();
        clr();
        send_lines(4, 8, 8, 8, 8);
        nvec++; if (cnt_wr !== 32 || cnt_ea !== 1 || cnt_fe !== 0) begin
            nbad++; $display("FAIL sim_next got wr=%0d ea=%0d fe=%0d exp 32 1 0", cnt_wr, cnt_ea, cnt_fe); end
    endtask

    task automatic test_control();
        enable = 1'b0;
        clr();
        vsync_cycle();
        vsync_cycle();
        send_lines(4, 8, 8, 8, 8);
        nvec++; if (cnt_wr !== 0 || cnt_fa !== 0 || busy !== 1'b0) begin
            nbad++; $display("FAIL ctl_disabled got wr=%0d fa=%0d busy=%b exp 0 0 0", cnt_wr, cnt_fa, busy); end
        enable = 1'b1;
        clr();
        vsync_cycle();
        send_lines(1, 8, 8, 8, 8);
        enable = 1'b0;
        send_lines(3, 8, 8, 8, 8);
        nvec++; if (cnt_wr !== 32 || cnt_ea !== 1) begin
            nbad++; $display("FAIL ctl_drop_en got wr=%0d ea=%0d exp 32 1", cnt_wr, cnt_ea); end
        vsync_cycle();
        vsync_cycle();
        send_lines(1, 8, 8, 8, 8);
        nvec++; if (cnt_fa !== 1 || cnt_wr !== 32 || busy !== 1'b0) begin
            nbad++; $display("FAIL ctl_to_idle got fa=%0d wr=%0d busy=%b exp 1 32 0", cnt_fa, cnt_wr, busy); end
    endtask

    task automatic test_rst_mid();
        enable = 1'b1;
        clr();
        vsync_cycle();
        send_lines(1, 8, 8, 8, 8);
        for (int p = 0; p < 3; p++) begin vif.de = 1'b1; vif.data = 24'(p); tick(); end
        nvec++; if (wr_en !== 1'b1) begin nbad++; $display("FAIL rst_pre got wr=%b exp 1", wr_en); end
        rst = 1'b1; tick();
        nvec++; if ({wr_en, falign, lalign, ealign, line_err, frame_err, overflow, busy} !== 8'h00) begin
            nbad++; $display("FAIL rst_mid_outs got %b exp 00000000", {wr_en, falign, lalign, ealign, line_err, frame_err, overflow, busy}); end
        rst = 1'b0;
        clr();
        for (int p = 3; p < 8; p++) begin vif.data = 24'(p); tick(); end
        vif.de = 1'b0; tick(); tick();
        nvec++; if (cnt_wr !== 0 || cnt_la !== 0 || cnt_ea !== 0 || busy !== 1'b0) begin
            nbad++; $display("FAIL rst_idle got wr=%0d la=%0d ea=%0d busy=%b exp 0 0 0 0", cnt_wr, cnt_la, cnt_ea, busy); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; fifo_full = 1'b0;
        hactive = 16'd8; vactive = 16'd4;
        vif.vsync = 1'b0; vif.hsync = 1'b0; vif.de = 1'b0; vif.data = '0;
        clr();
        test_reset();
        test_nominal();
        test_line_len();
        test_premature();
        test_backpressure();
        test_simul();
        test_control();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
